// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Two-stage pixel compositor for one player sprite and N_SPR enemy sprite
//   channels over a background, with player/enemy collision detection.
//
//   Stage 1 registers the colour inputs and blank_in, plus per-source opacity
//   flags. Stage 2 registers the composited pixel by strict priority:
//   blank, player, enemy sprite term, background. Input to output latency is
//   2 cycles, one pixel per cycle, no stalls.
//
//   Collisions are the stage-1 overlap of an opaque player with an opaque
//   enemy channel on a visible pixel while hit_en is high. They feed a
//   sticky hit flag and a per-frame accumulator. The accumulator is
//   summarised on every frame_start.
//
//   Build option: define SPRITE_COMPOSITOR_BLEND_EN to make the enemy sprite
//   term the OR of all opaque enemy colours. Without it, the lowest-index
//   opaque channel wins. Collision behaviour is the same in both builds.
//
// Ports
//   pixel_clk     in   clock, rising edge
//   rst           in   synchronous active-high reset
//   frame_start   in   one-cycle pulse at pixel (0,0)
//   blank_in      in   non-visible region
//   background    in   CW     background colour
//   player_color  in   CW     player sprite colour
//   sprite_color  in   N_SPR*CW  enemy colours, channel k at [k*CW +: CW]
//   hit_en        in   collision accumulation enable
//   hit_clear     in   clears the sticky hit flag
//   pixel_out     out  CW     composited colour
//   blank_out     out  blank_in aligned with pixel_out
//   hit           out  sticky collision flag
//   frame_hit     out  one-cycle pulse: previous frame had a collision
//   hit_mask      out  N_SPR  per-sprite collisions of the previous frame
//   hit_frames    out  16     saturating count of frames with a collision
module sprite_compositor #(
  parameter int              N_SPR       = 16,
  parameter int              CW          = 12,
  parameter logic [CW-1:0]   TRANSPARENT = '0
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  blank_in,
  input  logic [CW-1:0]         background,
  input  logic [CW-1:0]         player_color,
  input  logic [N_SPR*CW-1:0]   sprite_color,
  input  logic                  hit_en,
  input  logic                  hit_clear,
  output logic [CW-1:0]         pixel_out,
  output logic                  blank_out,
  output logic                  hit,
  output logic                  frame_hit,
  output logic [N_SPR-1:0]      hit_mask,
  output logic [15:0]           hit_frames
);

  // stage 1
  logic [CW-1:0]        r_bg;
  logic [CW-1:0]        r_player;
  logic [N_SPR*CW-1:0]  r_spr;
  logic                 r_blank1;
  logic                 r_player_op;
  logic [N_SPR-1:0]     r_spr_op;

  // stage 2
  logic [CW-1:0]        r_pixel;
  logic                 r_blank2;

  // collision state
  logic [N_SPR-1:0]     r_acc;
  logic [N_SPR-1:0]     r_hit_mask;
  logic                 r_frame_hit;
  logic                 r_hit;
  logic [15:0]          r_hit_frames;

  logic [N_SPR-1:0]     w_spr_op_in;
  logic [CW-1:0]        w_spr_term;
  logic [CW-1:0]        w_pixel_next;
  logic [N_SPR-1:0]     w_coll;

  always_comb begin
    w_spr_op_in = '0;
    for (int k = 0; k < N_SPR; k++) begin
      w_spr_op_in[k] = (sprite_color[k*CW +: CW] != TRANSPARENT);
    end
  end

`ifdef SPRITE_COMPOSITOR_BLEND_EN
  // Additive blend: overlapping opaque sprites combine by bitwise OR.
  always_comb begin
    w_spr_term = '0;
    for (int k = 0; k < N_SPR; k++) begin
      if (r_spr_op[k]) w_spr_term = w_spr_term | r_spr[k*CW +: CW];
    end
  end
`else
  // Walk from the highest channel down so the lowest opaque index is the last
  // assignment and therefore wins.
  always_comb begin
    w_spr_term = '0;
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (r_spr_op[k]) w_spr_term = r_spr[k*CW +: CW];
    end
  end
`endif

  always_comb begin
    w_pixel_next = r_bg;
    if (r_blank1)          w_pixel_next = '0;
    else if (r_player_op)  w_pixel_next = r_player;
    else if (|r_spr_op)    w_pixel_next = w_spr_term;
  end

  assign w_coll = {N_SPR{hit_en & ~r_blank1 & r_player_op}} & r_spr_op;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_bg        <= '0;
      r_player    <= '0;
      r_spr       <= '0;
      r_blank1    <= 1'b0;
      r_player_op <= 1'b0;
      r_spr_op    <= '0;
      r_pixel     <= '0;
      r_blank2    <= 1'b1;
    end else begin
      r_bg        <= background;
      r_player    <= player_color;
      r_spr       <= sprite_color;
      r_blank1    <= blank_in;
      r_player_op <= (player_color != TRANSPARENT);
      r_spr_op    <= w_spr_op_in;
      r_pixel     <= w_pixel_next;
      r_blank2    <= r_blank1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_hit_mask   <= '0;
      r_frame_hit  <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_frames <= '0;
    end else begin
      if (frame_start) begin
        r_hit_mask  <= r_acc;
        r_frame_hit <= |r_acc;
        if (|r_acc && (r_hit_frames != 16'hFFFF)) r_hit_frames <= r_hit_frames + 16'd1;
        // Seed with this cycle's collisions so the boundary pixel is kept.
        r_acc       <= w_coll;
      end else begin
        r_frame_hit <= 1'b0;
        r_acc       <= r_acc | w_coll;
      end
      // A new collision takes precedence over a simultaneous clear.
      if (|w_coll)         r_hit <= 1'b1;
      else if (hit_clear)  r_hit <= 1'b0;
    end
  end

  assign pixel_out  = r_pixel;
  assign blank_out  = r_blank2;
  assign hit        = r_hit;
  assign frame_hit  = r_frame_hit;
  assign hit_mask   = r_hit_mask;
  assign hit_frames = r_hit_frames;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;
  localparam int N  = 16;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            fs;
  logic            blank;
  logic [CW-1:0]   bg;
  logic [CW-1:0]   pl;
  logic [N*CW-1:0] spr;
  logic            he;
  logic            hc;
  logic [CW-1:0]   pixel_out;
  logic            blank_out;
  logic            hit;
  logic            frame_hit;
  logic [N-1:0]    hit_mask;
  logic [15:0]     hit_frames;

  int n_chk  = 0;
  int n_pass = 0;
  logic [CW:0] sb_q[$];

  sprite_compositor #(.N_SPR(N), .CW(CW), .TRANSPARENT('0)) dut (
    .pixel_clk   (clk),
    .rst         (rst),
    .frame_start (fs),
    .blank_in    (blank),
    .background  (bg),
    .player_color(pl),
    .sprite_color(spr),
    .hit_en      (he),
    .hit_clear   (hc),
    .pixel_out   (pixel_out),
    .blank_out   (blank_out),
    .hit         (hit),
    .frame_hit   (frame_hit),
    .hit_mask    (hit_mask),
    .hit_frames  (hit_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference composite: {blank, colour}
  function automatic logic [CW:0] model_pix();
    logic [CW-1:0] term;
    logic          any;
    term = '0;
    any  = 1'b0;
`ifdef SPRITE_COMPOSITOR_BLEND_EN
    for (int k = 0; k < N; k++)
      if (spr[k*CW +: CW] != '0) begin
        term = term | spr[k*CW +: CW];
        any  = 1'b1;
      end
`else
    for (int k = 0; k < N; k++)
      if (!any && spr[k*CW +: CW] != '0) begin
        term = spr[k*CW +: CW];
        any  = 1'b1;
      end
`endif
    if (blank)          return {1'b1, {CW{1'b0}}};
    else if (pl != '0)  return {1'b0, pl};
    else if (any)       return {1'b0, term};
    else                return {1'b0, bg};
  endfunction

  task automatic cycle();
    logic [CW:0] e;
    if (rst) sb_q.delete();
    else sb_q.push_back(model_pix());
    @(posedge clk);
    #1;
    if (!rst && sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      chk("pixel", {19'd0, blank_out, pixel_out}, {19'd0, e});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      fs = 1'b0; blank = 1'b1; bg = '0; pl = '0; spr = '0;
      cycle();
    end
  endtask

  task automatic frame_pulse();
    fs = 1'b1; blank = 1'b1; bg = '0; pl = '0; spr = '0;
    cycle();
    fs = 1'b0;
  endtask

  task automatic overlap(input int ch, input logic [CW-1:0] pc, input logic [CW-1:0] sc, input int n);
    for (int i = 0; i < n; i++) begin
      fs = 1'b0; blank = 1'b0; bg = 12'h555; pl = pc;
      spr = '0;
      spr[ch*CW +: CW] = sc;
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; blank = 1'b0; bg = '0; pl = '0; spr = '0; he = 1'b0; hc = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_pixel", {20'd0, pixel_out}, 32'd0);
    chk("rst_blank", {31'd0, blank_out}, 32'd1);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_frame_hit", {31'd0, frame_hit}, 32'd0);
    chk("rst_hit_mask", {16'd0, hit_mask}, 32'd0);
    chk("rst_hit_frames", {16'd0, hit_frames}, 32'd0);
    rst = 1'b0;

    // Directed priority vectors
    blank = 1'b0; pl = '0; bg = 12'h123; spr = '0;
    spr[0*CW +: CW] = 12'h00F; spr[3*CW +: CW] = 12'h0F0;
    cycle();
    pl = 12'hF00; cycle();
    pl = '0; spr = '0; cycle();
    blank = 1'b1; pl = 12'hABC; cycle();
    blank = 1'b0; spr[15*CW +: CW] = 12'h777; spr[9*CW +: CW] = 12'h008; cycle();

    // Random traffic, collisions disabled
    for (int i = 0; i < 300; i++) begin
      blank = ($urandom_range(0, 7) == 0);
      bg    = CW'($urandom);
      pl    = ($urandom_range(0, 3) == 0) ? CW'($urandom) : '0;
      spr   = '0;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) spr[k*CW +: CW] = CW'($urandom);
      cycle();
    end
    idle(3);
    chk("no_hit_when_disabled", {31'd0, hit}, 32'd0);

    // Collision on sprite 5 for 3 pixels
    he = 1'b1;
    frame_pulse();
    idle(2);
    overlap(5, 12'hF00, 12'h0F0, 3);
    idle(3);
    chk("hit_set", {31'd0, hit}, 32'd1);
    frame_pulse();
    chk("mask_s5", {16'd0, hit_mask}, 32'h0020);
    chk("frame_hit_pulse", {31'd0, frame_hit}, 32'd1);
    chk("hit_frames_1", {16'd0, hit_frames}, 32'd1);
    idle(1);
    chk("frame_hit_single", {31'd0, frame_hit}, 32'd0);

    // Set beats simultaneous clear; clear alone then drops hit
    overlap(2, 12'hF00, 12'h00F, 1);
    hc = 1'b1;
    idle(1);
    chk("set_wins_clear", {31'd0, hit}, 32'd1);
    idle(1);
    chk("clear_alone", {31'd0, hit}, 32'd0);
    hc = 1'b0;
    idle(2);
    frame_pulse();
    chk("mask_s2", {16'd0, hit_mask}, 32'h0004);
    chk("hit_frames_2", {16'd0, hit_frames}, 32'd2);
    chk("frame_hit_2", {31'd0, frame_hit}, 32'd1);

    // Overlap with hit_en low
    he = 1'b0;
    idle(2);
    overlap(5, 12'hF00, 12'h0F0, 3);
    idle(3);
    chk("hit_en_off_hit", {31'd0, hit}, 32'd0);
    frame_pulse();
    chk("hit_en_off_mask", {16'd0, hit_mask}, 32'd0);
    chk("hit_en_off_frame_hit", {31'd0, frame_hit}, 32'd0);
    chk("hit_en_off_frames", {16'd0, hit_frames}, 32'd2);

    // Saturation: back-to-back frame_start with a collision every pixel
    he = 1'b1;
    idle(2);
    for (int i = 0; i < 65600; i++) begin
      fs = 1'b1; blank = 1'b0; bg = 12'h111; pl = 12'hF00;
      spr = '0; spr[1*CW +: CW] = 12'h0F0;
      cycle();
    end
    fs = 1'b0;
    idle(3);
    chk("hit_frames_sat", {16'd0, hit_frames}, 32'hFFFF);
    overlap(1, 12'hF00, 12'h0F0, 1);
    idle(3);
    frame_pulse();
    chk("hit_frames_stay_sat", {16'd0, hit_frames}, 32'hFFFF);
    chk("sat_frame_hit", {31'd0, frame_hit}, 32'd1);
    chk("sat_mask", {16'd0, hit_mask}, 32'h0002);

    // Reset mid-frame discards accumulated collisions
    idle(2);
    overlap(7, 12'hF00, 12'h0F0, 3);
    blank = 1'b0; pl = 12'hF00; spr = '0; spr[7*CW +: CW] = 12'h0F0;
    rst = 1'b1;
    cycle();
    chk("midrst_pixel", {20'd0, pixel_out}, 32'd0);
    chk("midrst_blank", {31'd0, blank_out}, 32'd1);
    cycle();
    chk("midrst_hit", {31'd0, hit}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fs = 1'b0; blank = 1'b0; bg = 12'h321;
      pl = (i < 2) ? 12'h0AA : '0;
      spr = '0;
      if (i >= 2) spr[7*CW +: CW] = 12'h0F0;
      cycle();
    end
    idle(3);
    frame_pulse();
    chk("post_rst_mask", {16'd0, hit_mask}, 32'd0);
    chk("post_rst_frame_hit", {31'd0, frame_hit}, 32'd0);
    chk("post_rst_frames", {16'd0, hit_frames}, 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
